// File: rtl/ctrl_interrup_pkg.sv
// Shared types and helpers for the interrupt controller.
package ctrl_interrup_pkg;
  localparam int NUM_SRC = 4;
  localparam int VEC_W   = 10;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  // Fixed-priority encoder: the lowest set index wins (port 1 is highest).
  function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_SRC-1:0] cand);
    logic [ID_W-1:0] win;
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win = ID_W'(i);
    end
    return win;
  endfunction
endpackage

// File: rtl/ctrl_interrup_detector_flanco.sv
// Two-flop synchroniser followed by a rising-edge detector for one request line.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  output logic edge_o
);
  logic sync1_q, sync2_q, prev_q;

  // Synchronise the asynchronous line and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;
endmodule

// File: rtl/ctrl_interrup.sv
// Interrupt controller: edge-latched pending requests, enable mask,
// fixed-priority arbitration and a request/ack/return handshake FSM.
module ctrl_interrup
  import ctrl_interrup_pkg::*;
#(
  parameter logic [VEC_W-1:0] VEC_BASE   = 10'd1000,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 10'd4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] int_req,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_d,
  input  logic               ack,
  input  logic               fin_interrup,
  output logic               irq,
  output logic [VEC_W-1:0]   vector,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] pending_q, pending_d, clr;
  logic [NUM_SRC-1:0] mask_q, mask_d_nxt;
  logic [NUM_SRC-1:0] cand;
  logic [ID_W-1:0]    win;
  logic [VEC_W-1:0]   win_vec;
  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [VEC_W-1:0]   vector_q, vector_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_det
      detector_flanco u_det (
        .clk    (clk),
        .reset  (reset),
        .req_i  (int_req[gi]),
        .edge_o (edge_det[gi])
      );
    end
  endgenerate

  assign cand    = pending_q & mask_q;
  assign win     = prio_enc(cand);
  assign win_vec = VEC_BASE + VEC_W'(win) * VEC_STRIDE;

  // Pending update: ack clears the served bit, a fresh edge sets it (set wins).
  always_comb begin
    clr = '0;
    if (state_q == REQ && ack) clr[id_q] = 1'b1;
    pending_d  = (pending_q & ~clr) | edge_det;
    mask_d_nxt = mask_we ? mask_d : mask_q;
  end

  // Handshake FSM; id and vector are captured only when leaving IDLE.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    vector_d = vector_q;
    case (state_q)
      IDLE: if (|cand) begin
        id_d     = win;
        vector_d = win_vec;
        state_d  = REQ;
      end
      REQ:     if (ack) state_d = SERV;
      SERV:    if (fin_interrup) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, id, vector, pending and mask registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      id_q      <= '0;
      vector_q  <= VEC_BASE;
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      vector_q  <= vector_d;
      pending_q <= pending_d;
      mask_q    <= mask_d_nxt;
    end
  end

  assign irq        = (state_q == REQ);
  assign in_service = (state_q == SERV);
  assign vector     = vector_q;
  assign pending    = pending_q;
endmodule

// File: tb/tb_ctrl_interrup.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model built from sampled-input history.
module tb_ctrl_interrup;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] int_req = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_d = '0;
  logic       ack = 1'b0;
  logic       fin_interrup = 1'b0;
  logic       irq;
  logic [9:0] vector;
  logic       in_service;
  logic [3:0] pending;

  int total = 0;
  int bad = 0;

  // model state
  logic [3:0] h1, h2, h3;   // int_req sampled at the previous 1, 2, 3 edges
  logic [3:0] m_pend, m_mask;
  int         m_phase;      // 0 waiting, 1 requesting, 2 handler running
  int         m_id;

  ctrl_interrup dut (
    .clk(clk), .reset(reset), .int_req(int_req), .mask_we(mask_we),
    .mask_d(mask_d), .ack(ack), .fin_interrup(fin_interrup), .irq(irq),
    .vector(vector), .in_service(in_service), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    h1 = '0; h2 = '0; h3 = '0;
    m_pend = '0; m_mask = 4'hF; m_phase = 0; m_id = 0;
  endtask

  // One rising edge: a line that read 0 then 1 three and two samples ago
  // becomes pending now.
  task automatic model_step();
    logic [3:0] rise, cand;
    rise = h2 & ~h3;
    cand = m_pend & m_mask;
    if (mask_we) m_mask = mask_d;
    if (m_phase == 1) begin
      if (ack) begin
        m_pend[m_id] = 1'b0;
        m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (fin_interrup) m_phase = 0;
    end else if (cand != 0) begin
      for (int i = 3; i >= 0; i--) if (cand[i]) m_id = i;
      m_phase = 1;
    end
    m_pend = m_pend | rise;
    h3 = h2; h2 = h1; h1 = int_req;
  endtask

  task automatic compare_all();
    chk("irq", int'(irq), int'(m_phase == 1));
    chk("in_service", int'(in_service), int'(m_phase == 2));
    chk("vector", int'(vector), (1000 + 4 * m_id) % 1024);
    chk("pending", int'(pending), int'(m_pend));
  endtask

  task automatic cycle(input logic [3:0] rq, input logic mwe, input logic [3:0] md,
                       input logic a, input logic f);
    @(negedge clk);
    int_req = rq; mask_we = mwe; mask_d = md; ack = a; fin_interrup = f;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    $display("cyc req=%b mwe=%b md=%b ack=%b fin=%b -> irq=%b vec=%0d ins=%b pend=%b",
             rq, mwe, md, a, f, irq, vector, in_service, pending);
  endtask

  task automatic async_reset();
    #1 reset = 1'b0;
    int_req = '0; mask_we = 1'b0; ack = 1'b0; fin_interrup = 1'b0;
    #1;
    chk("rst_irq", int'(irq), 0);
    chk("rst_ins", int'(in_service), 0);
    chk("rst_vec", int'(vector), 1000);
    chk("rst_pend", int'(pending), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] rq;
    model_reset();
    #12;
    chk("por_irq", int'(irq), 0);
    chk("por_vec", int'(vector), 1000);
    chk("por_pend", int'(pending), 0);
    @(negedge clk);
    reset = 1'b1;

    // quiet after reset
    for (int i = 0; i < 5; i++) cycle(4'h0, 0, 4'h0, 0, 0);
    chk("idle_vec", int'(vector), 1000);

    // single request on port 3 (bit 2)
    cycle(4'h4, 0, 4'h0, 0, 0);
    cycle(4'h4, 0, 4'h0, 0, 0);
    cycle(4'h4, 0, 4'h0, 0, 0);
    chk("d1_pend", int'(pending), 4);
    chk("d1_irq_early", int'(irq), 0);
    cycle(4'h4, 0, 4'h0, 0, 0);
    chk("d1_irq", int'(irq), 1);
    chk("d1_vec", int'(vector), 1008);
    // higher-priority arrival while requesting must not disturb the request
    cycle(4'h5, 0, 4'h0, 0, 0);
    cycle(4'h5, 0, 4'h0, 0, 0);
    cycle(4'h5, 0, 4'h0, 0, 0);
    chk("d1_frozen_vec", int'(vector), 1008);
    chk("d1_pend2", int'(pending), 5);
    cycle(4'h5, 0, 4'h0, 1, 1);
    chk("d1_ack_ins", int'(in_service), 1);
    chk("d1_ack_pend", int'(pending), 1);
    cycle(4'h5, 0, 4'h0, 0, 1);
    chk("d1_fin_ins", int'(in_service), 0);
    cycle(4'h5, 0, 4'h0, 0, 0);
    chk("d1_next_vec", int'(vector), 1000);
    cycle(4'h0, 0, 4'h0, 1, 0);
    cycle(4'h0, 0, 4'h0, 0, 1);

    // masked source still pends but is not arbitrated
    cycle(4'h0, 1, 4'hE, 0, 0);
    for (int i = 0; i < 4; i++) cycle(4'h1, 0, 4'h0, 0, 0);
    chk("mask_pend", int'(pending), 1);
    chk("mask_irq", int'(irq), 0);
    cycle(4'h1, 1, 4'hF, 0, 0);
    cycle(4'h1, 0, 4'h0, 0, 0);
    chk("unmask_irq", int'(irq), 1);
    chk("unmask_vec", int'(vector), 1000);
    cycle(4'h0, 0, 4'h0, 1, 0);
    cycle(4'h0, 0, 4'h0, 0, 1);

    // random traffic
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      cycle(rq, ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end

    // reset while a handler runs and another source is pending
    async_reset();
    for (int i = 0; i < 4; i++) cycle(4'h1, 0, 4'h0, 0, 0);
    cycle(4'h1, 0, 4'h0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(4'h3, 0, 4'h0, 0, 0);
    chk("pre_rst_ins", int'(in_service), 1);
    chk("pre_rst_pend", int'(pending), 2);
    async_reset();
    cycle(4'h0, 0, 4'h0, 0, 1);
    chk("stray_fin_ins", int'(in_service), 0);
    chk("stray_fin_irq", int'(irq), 0);
    for (int i = 0; i < 4; i++) cycle(4'h0, 0, 4'h0, 0, 0);
    chk("post_rst_pend", int'(pending), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
